pc_gen_ras: RTL and testbench
=============================

Name: pc_gen_ras

Overview:
Parametrised next-generation program-counter unit for the MIPS150 fetch stage.
- Computes the sequential PC internally and selects among six next-PC sources.
- Adds a circular return-address stack (RAS) that predicts JR returns.
- Supports a trap vector and a one-cycle redirect indication to the fetch/flush logic.

Parameters:
WIDTH, 32, PC/address width in bits
RESET_VECTOR, 0, PC_IF value loaded on reset
TRAP_VECTOR, 32'h0000_0180, target for PC_Sel = 3'b101
INC, 4, sequential increment added to PC_IF
RAS_DEPTH, 4, RAS entries; power of two, >= 2
RAS_AW, 2, log2(RAS_DEPTH)

Ports:
CLK  input  1  clock, all state on posedge
RST  input  1  asynchronous active-low reset
EN  input  1  advance enable; 0 = stall, all state held
PC_Sel  input  3  next-PC source select
PC_Branch  input  WIDTH  branch target
PC_JAL  input  WIDTH  jump/JAL target
JR  input  WIDTH  register jump target
Link_Addr  input  WIDTH  return address written on push
RAS_Push  input  1  push Link_Addr (JAL/JALR)
RAS_Pop  input  1  pop top entry (JR $ra)
PC_IF  output  WIDTH  current fetch PC
PC_4  output  WIDTH  PC_IF + INC, combinational
RAS_Top  output  WIDTH  current top entry; 0 when empty
RAS_Count  output  RAS_AW+1  valid entries, 0..RAS_DEPTH
Redirect  output  1  registered; 1 for the cycle after a non-sequential load
RAS_Ovf  output  1  sticky; set when a push overwrites the oldest entry
RAS_Unf  output  1  registered one-cycle pulse on pop-while-empty

Behaviour:
- Reset (RST=0, async): PC_IF=RESET_VECTOR; RAS pointer=0; RAS_Count=0; all RAS entries=0; Redirect=0; RAS_Ovf=0; RAS_Unf=0. Takes effect immediately, mid-operation included.
- PC_4 = PC_IF + INC, truncated to WIDTH; wraps modulo 2^WIDTH.
- Next-PC mux, loaded on posedge when EN=1:
  - 000: PC_4
  - 001: PC_Branch
  - 010: JR
  - 011: PC_JAL
  - 100: RAS_Top if RAS_Count>0, else JR (fallback)
  - 101: TRAP_VECTOR
  - 110/111: PC_4
- Redirect: next value = EN & (PC_Sel not 000/110/111). Redirect=0 when EN=0.
- RAS organisation: circular buffer; top pointer = index of last written entry. Only acts when EN=1.
- Push only: pointer+1 (mod RAS_DEPTH); entry[new ptr]=Link_Addr; Count+1.
  - At Count=RAS_DEPTH: Count saturates, oldest entry is overwritten, RAS_Ovf set.
- Pop only, Count>0: pointer-1 (mod); Count-1; entry contents unchanged.
- Pop only, Count=0: no state change; RAS_Unf=1 next cycle.
- Push and pop in the same cycle: entry[ptr]=Link_Addr; pointer and Count unchanged (replace top); no Ovf/Unf.
- Selection versus pop in the same cycle: PC_Sel=100 with RAS_Pop uses the pre-pop RAS_Top.
- RAS_Top = entry[ptr] when Count>0, else 0; combinational from registered state.
- EN=0: PC_IF, RAS, Count and flags are held; RAS_Unf and Redirect go to 0. Push/pop are ignored.
- RAS_Ovf clears only on reset.

Optional Feature:
Macro PC_ALIGN_CHECK_EN.
- Defined: adds output Misaligned (1 bit, registered, reset 0). It is set to 1 when the value loaded into PC_IF has bits[1:0] != 0, and cleared on the next aligned load. The PC value is still loaded unmodified.
- Not defined: the port is absent and no check logic is generated.

Test Plan:
- Reset with RST=0, then release; EN=1, PC_Sel=000 for 3 cycles -> PC_IF = 0, 4, 8, 12; Redirect=0 throughout.
- PC_Sel=001 with PC_Branch=0x100 -> PC_IF=0x100 next cycle and Redirect=1 for exactly one cycle. Then EN=0 for 2 cycles -> PC_IF stays 0x100, Redirect=0.
- Push 0x10, 0x20, 0x30, 0x40, 0x50 with RAS_DEPTH=4 -> Count=4, RAS_Ovf=1, RAS_Top=0x50. Four pops give tops 0x50, 0x40, 0x30, 0x20. A fifth pop -> RAS_Unf pulses once and Count stays 0.
- Count=2 with top 0x20; PC_Sel=100 and RAS_Pop=1 -> PC_IF=0x20, Count=1, RAS_Top=0x10. With Count=0, PC_Sel=100 and JR=0x77 -> PC_IF=0x77.
- Simultaneous push 0x99 and pop at Count=2 -> Count=2, RAS_Top=0x99. Assert RST low mid-cycle -> PC_IF=RESET_VECTOR and Count=0 immediately.
- With PC_ALIGN_CHECK_EN defined: PC_Sel=010, JR=0x102 -> Misaligned=1. A following sequential step to 0x106 keeps Misaligned=1. Then PC_JAL=0x200 -> Misaligned=0.

Source files
------------

// File: rtl/pc_gen_ras_if.sv
// pc_gen_ras_if: groups the next-PC select, jump targets, return-address
// stack controls and the PC/RAS status outputs of pc_gen_ras.
//   master : the fetch/decode control side (drives selects and targets,
//            observes PC and RAS status)
//   slave  : the PC generator itself
// There is no valid/ready handshake on this bus: every input is sampled on
// each CLK rising edge where EN=1, and EN=0 is a full stall.
// Optional macro PC_ALIGN_CHECK_EN adds the Misaligned status signal.
interface pc_gen_ras_if #(
  parameter int WIDTH  = 32,
  parameter int RAS_AW = 2
);
  logic              EN;
  logic [2:0]        PC_Sel;
  logic [WIDTH-1:0]  PC_Branch;
  logic [WIDTH-1:0]  PC_JAL;
  logic [WIDTH-1:0]  JR;
  logic [WIDTH-1:0]  Link_Addr;
  logic              RAS_Push;
  logic              RAS_Pop;
  logic [WIDTH-1:0]  PC_IF;
  logic [WIDTH-1:0]  PC_4;
  logic [WIDTH-1:0]  RAS_Top;
  logic [RAS_AW:0]   RAS_Count;
  logic              Redirect;
  logic              RAS_Ovf;
  logic              RAS_Unf;
`ifdef PC_ALIGN_CHECK_EN
  logic              Misaligned;
`endif

  modport master (
    output EN, PC_Sel, PC_Branch, PC_JAL, JR, Link_Addr, RAS_Push, RAS_Pop,
    input  PC_IF, PC_4, RAS_Top, RAS_Count, Redirect, RAS_Ovf, RAS_Unf
`ifdef PC_ALIGN_CHECK_EN
    , input Misaligned
`endif
  );

  modport slave (
    input  EN, PC_Sel, PC_Branch, PC_JAL, JR, Link_Addr, RAS_Push, RAS_Pop,
    output PC_IF, PC_4, RAS_Top, RAS_Count, Redirect, RAS_Ovf, RAS_Unf
`ifdef PC_ALIGN_CHECK_EN
    , output Misaligned
`endif
  );
endinterface

// File: rtl/pc_gen_ras.sv
// pc_gen_ras: next-PC generator for the MIPS150 fetch stage with a circular
// return-address stack (RAS) used to predict JR returns.
// Ports:
//   CLK  - clock, all state updates on the rising edge
//   RST  - asynchronous active-low reset
//   pc   - pc_gen_ras_if.slave: EN, PC_Sel, targets, RAS push/pop in;
//          PC_IF, PC_4, RAS_Top, RAS_Count, Redirect, RAS_Ovf, RAS_Unf out
// PC_Sel: 000 seq, 001 branch, 010 JR, 011 JAL, 100 RAS (JR if empty),
//         101 trap vector, 110/111 seq.
// Optional macro PC_ALIGN_CHECK_EN: adds registered pc.Misaligned, set when
// the PC being loaded has nonzero low two bits.
module pc_gen_ras #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0180,
  parameter int               INC          = 4,
  parameter int               RAS_DEPTH    = 4,
  parameter int               RAS_AW       = 2
) (
  input  logic             CLK,
  input  logic             RST,
  pc_gen_ras_if.slave      pc
);

  localparam logic [RAS_AW:0] FULL = (RAS_AW+1)'(RAS_DEPTH);

  logic [WIDTH-1:0]  pc_q;
  logic [WIDTH-1:0]  ras_q [RAS_DEPTH];
  logic [RAS_AW-1:0] ptr_q;
  logic [RAS_AW:0]   cnt_q;
  logic              redirect_q;
  logic              ovf_q;
  logic              unf_q;
  logic [WIDTH-1:0]  pc_4;
  logic [WIDTH-1:0]  ras_top;
  logic [WIDTH-1:0]  next_pc;
  logic              non_seq;
  logic              empty;

  assign empty   = (cnt_q == '0);
  assign pc_4    = pc_q + WIDTH'(INC);
  assign ras_top = empty ? '0 : ras_q[ptr_q];

  // ras_top is the pre-pop value, so a return predicted in the same cycle
  // as its pop uses the entry being popped.
  always_comb begin
    next_pc = pc_4;
    non_seq = 1'b0;
    case (pc.PC_Sel)
      3'b001: begin next_pc = pc.PC_Branch;                  non_seq = 1'b1; end
      3'b010: begin next_pc = pc.JR;                         non_seq = 1'b1; end
      3'b011: begin next_pc = pc.PC_JAL;                     non_seq = 1'b1; end
      3'b100: begin next_pc = empty ? pc.JR : ras_top;       non_seq = 1'b1; end
      3'b101: begin next_pc = TRAP_VECTOR;                   non_seq = 1'b1; end
      default: begin next_pc = pc_4;                         non_seq = 1'b0; end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc_q       <= RESET_VECTOR;
      ptr_q      <= '0;
      cnt_q      <= '0;
      redirect_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else if (pc.EN) begin
      pc_q       <= next_pc;
      redirect_q <= non_seq;
      unf_q      <= pc.RAS_Pop && !pc.RAS_Push && empty;
      if (pc.RAS_Push && pc.RAS_Pop) begin
        // Replace the top in place; depth and pointer are unaffected.
        ras_q[ptr_q] <= pc.Link_Addr;
      end else if (pc.RAS_Push) begin
        // When full, advancing the pointer lands on the oldest entry.
        ptr_q        <= ptr_q + 1'b1;
        ras_q[ptr_q + 1'b1] <= pc.Link_Addr;
        if (cnt_q == FULL) ovf_q <= 1'b1;
        else               cnt_q <= cnt_q + 1'b1;
      end else if (pc.RAS_Pop && !empty) begin
        ptr_q <= ptr_q - 1'b1;
        cnt_q <= cnt_q - 1'b1;
      end
    end else begin
      redirect_q <= 1'b0;
      unf_q      <= 1'b0;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic misaligned_q;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)        misaligned_q <= 1'b0;
    else if (pc.EN)  misaligned_q <= |next_pc[1:0];
  end
  assign pc.Misaligned = misaligned_q;
`endif

  assign pc.PC_IF     = pc_q;
  assign pc.PC_4      = pc_4;
  assign pc.RAS_Top   = ras_top;
  assign pc.RAS_Count = cnt_q;
  assign pc.Redirect  = redirect_q;
  assign pc.RAS_Ovf   = ovf_q;
  assign pc.RAS_Unf   = unf_q;

endmodule

// File: tb/tb_pc_gen_ras.sv
// tb_pc_gen_ras: directed test of pc_gen_ras (default parameters).
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_pc_gen_ras;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [31:0] exp_q[$];

  pc_gen_ras_if #(.WIDTH(32), .RAS_AW(2)) bus ();

  pc_gen_ras dut (
    .CLK (clk),
    .RST (rst_n),
    .pc  (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [2:0] sel,
                       input logic push, input logic pop,
                       input logic [31:0] link);
    bus.EN        = en;
    bus.PC_Sel    = sel;
    bus.RAS_Push  = push;
    bus.RAS_Pop   = pop;
    bus.Link_Addr = link;
  endtask

  task automatic idle();
    drive(1'b1, 3'b000, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic push(input logic [31:0] v);
    drive(1'b1, 3'b000, 1'b1, 1'b0, v);
    step();
  endtask

  initial begin
    logic [31:0] tops [4];
    total = 0;
    bad   = 0;
    tops[0] = 32'h50; tops[1] = 32'h40; tops[2] = 32'h30; tops[3] = 32'h20;
    rst_n = 1'b0;
    drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
    bus.PC_Branch = '0; bus.PC_JAL = '0; bus.JR = '0;
    #12;
    chk("rst_pc",    bus.PC_IF, 32'h0);
    chk("rst_pc4",   bus.PC_4, 32'h4);
    chk("rst_cnt",   32'(bus.RAS_Count), 32'h0);
    chk("rst_top",   bus.RAS_Top, 32'h0);
    chk("rst_flags", {29'h0, bus.Redirect, bus.RAS_Ovf, bus.RAS_Unf}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // sequential fetch
    idle();
    exp_q.push_back(32'h4); exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("seq_pc", bus.PC_IF, exp_q.pop_front());
      chk("seq_redir", 32'(bus.Redirect), 32'h0);
    end

    // branch, then stall
    bus.PC_Branch = 32'h100;
    drive(1'b1, 3'b001, 1'b0, 1'b0, 32'h0);
    step();
    chk("br_pc", bus.PC_IF, 32'h100);
    chk("br_redir", 32'(bus.Redirect), 32'h1);
    drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_pc", bus.PC_IF, 32'h100);
      chk("stall_redir", 32'(bus.Redirect), 32'h0);
    end

    // five pushes into a depth-4 stack
    push(32'h10); push(32'h20); push(32'h30); push(32'h40);
    chk("full_ovf0", 32'(bus.RAS_Ovf), 32'h0);
    push(32'h50);
    chk("ovf_cnt", 32'(bus.RAS_Count), 32'h4);
    chk("ovf_flag", 32'(bus.RAS_Ovf), 32'h1);
    chk("ovf_top", bus.RAS_Top, 32'h50);
    for (int i = 0; i < 4; i++) begin
      chk("pop_top", bus.RAS_Top, tops[i]);
      drive(1'b1, 3'b000, 1'b0, 1'b1, 32'h0);
      step();
    end
    chk("empty_cnt", 32'(bus.RAS_Count), 32'h0);
    chk("empty_top", bus.RAS_Top, 32'h0);
    chk("no_unf", 32'(bus.RAS_Unf), 32'h0);
    step();
    chk("unf_pulse", 32'(bus.RAS_Unf), 32'h1);
    chk("unf_cnt", 32'(bus.RAS_Count), 32'h0);
    idle();
    step();
    chk("unf_clear", 32'(bus.RAS_Unf), 32'h0);
    chk("ovf_sticky", 32'(bus.RAS_Ovf), 32'h1);

    // RAS-predicted return with simultaneous pop
    push(32'h10); push(32'h20);
    bus.JR = 32'h55;
    drive(1'b1, 3'b100, 1'b0, 1'b1, 32'h0);
    step();
    chk("ret_pc", bus.PC_IF, 32'h20);
    chk("ret_cnt", 32'(bus.RAS_Count), 32'h1);
    chk("ret_top", bus.RAS_Top, 32'h10);
    chk("ret_redir", 32'(bus.Redirect), 32'h1);
    drive(1'b1, 3'b000, 1'b0, 1'b1, 32'h0);
    step();
    bus.JR = 32'h77;
    drive(1'b1, 3'b100, 1'b0, 1'b0, 32'h0);
    step();
    chk("ret_fallback", bus.PC_IF, 32'h77);

    // push and pop together replaces the top
    push(32'h10); push(32'h20);
    drive(1'b1, 3'b000, 1'b1, 1'b1, 32'h99);
    step();
    chk("repl_cnt", 32'(bus.RAS_Count), 32'h2);
    chk("repl_top", bus.RAS_Top, 32'h99);
    chk("repl_unf", 32'(bus.RAS_Unf), 32'h0);
    // push ignored while stalled
    drive(1'b0, 3'b000, 1'b1, 1'b0, 32'hAA);
    step();
    chk("stall_push", 32'(bus.RAS_Count), 32'h2);
    drive(1'b1, 3'b000, 1'b0, 1'b1, 32'h0);
    step();
    chk("repl_below", bus.RAS_Top, 32'h10);

    // trap, unused select, JAL, PC_4 wrap
    drive(1'b1, 3'b101, 1'b0, 1'b0, 32'h0);
    step();
    chk("trap_pc", bus.PC_IF, 32'h180);
    drive(1'b1, 3'b110, 1'b0, 1'b0, 32'h0);
    step();
    chk("sel6_pc", bus.PC_IF, 32'h184);
    chk("sel6_redir", 32'(bus.Redirect), 32'h0);
    bus.PC_JAL = 32'h300;
    drive(1'b1, 3'b011, 1'b0, 1'b0, 32'h0);
    step();
    chk("jal_pc", bus.PC_IF, 32'h300);
    bus.JR = 32'hFFFF_FFFC;
    drive(1'b1, 3'b010, 1'b0, 1'b0, 32'h0);
    step();
    chk("wrap_pc4", bus.PC_4, 32'h0);
    idle();
    step();
    chk("wrap_pc", bus.PC_IF, 32'h0);

    // asynchronous reset mid-cycle
    push(32'h44);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", bus.PC_IF, 32'h0);
    chk("arst_cnt", 32'(bus.RAS_Count), 32'h0);
    chk("arst_ovf", 32'(bus.RAS_Ovf), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

`ifdef PC_ALIGN_CHECK_EN
    bus.JR = 32'h102;
    drive(1'b1, 3'b010, 1'b0, 1'b0, 32'h0);
    step();
    chk("mis_set", 32'(bus.Misaligned), 32'h1);
    idle();
    step();
    chk("mis_seq_pc", bus.PC_IF, 32'h106);
    chk("mis_hold", 32'(bus.Misaligned), 32'h1);
    bus.PC_JAL = 32'h200;
    drive(1'b1, 3'b011, 1'b0, 1'b0, 32'h0);
    step();
    chk("mis_clear", 32'(bus.Misaligned), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
